mac_tx_framer: RTL and testbench
================================

Name: mac_tx_framer

Overview:
- Parametrised successor of the Ethernet MAC transmit path.
- Accepts a frame length plus a byte stream and serialises the frame LSB-first: preamble, SFD, data, automatic padding to minimum frame size, CRC-32 FCS, then a programmable inter-frame gap.
- Bit rate is a clock divider; feeds the PLS encoder through txen_o/txd_o.
- Adds stream back-pressure, padding, underrun detection, abort and a completion pulse.

Parameters:
- CLK_DIV, 2, clock cycles per serial bit (≥1).
- LEN_W, 11, width of the frame length field, in bytes.
- MIN_FRAME, 60, minimum data+pad bytes before FCS; 0 disables padding.
- PRE_BYTES, 7, number of 0x55 preamble bytes before the SFD.
- IFG_BITS, 96, bit times of silence after the FCS.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- len_i  in  LEN_W  data byte count (destination address through payload, excluding FCS); latched with start_i.
- abort_i  in  1  terminate the current frame.
- busy_o  out  1  high in every state except IDLE.
- data_i  in  8  next frame byte.
- data_valid_i  in  1  data_i valid.
- data_ready_o  out  1  framer accepts data_i this cycle.
- txen_o  out  1  serial data enable to the PLS.
- txd_o  out  1  serial data bit.
- done_o  out  1  one-cycle pulse when the IFG ends.
- underrun_o  out  1  one-cycle pulse when the stream starved mid-frame.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; CRC register 0xFFFFFFFF; counters 0.
- Bit timing: a divider counts 0..CLK_DIV-1. Each bit is held for exactly CLK_DIV cycles. All state and bit transitions occur on divider wrap.
- Byte buffer: one 8-bit holding register plus a full flag.
  - data_ready_o = !full while in PRE, SFD or DATA with data bytes still outstanding.
  - A transfer occurs when data_valid_i && data_ready_o; full is set on transfer and cleared when the byte is loaded into the shifter.
- IDLE:
  - txen_o = 0.
  - On start_i: latch len_i, clear counters, load the CRC register with 0xFFFFFFFF, and go to PRE.
  - txen_o = 1 and the first preamble bit appear on the cycle after start_i is sampled.
  - start_i is ignored while busy_o = 1.
- PRE: PRE_BYTES × 0x55, LSB-first, so the line reads 1,0,1,0,...
- SFD: 0xD5 LSB-first; the line ends in 1,1.
  - On the last SFD bit: if len_i = 0, go to PAD or FCS. Otherwise the holding register must be full, or an underrun occurs.
- DATA: shift out len_i bytes LSB-first; every bit updates the CRC.
  - At each byte boundary the next byte is taken from the holding register.
  - Holding register empty at a boundary: underrun_o pulses, txen_o = 0 from the next cycle, go to IFG. The frame is truncated with no FCS.
- PAD: only entered if len_i < MIN_FRAME. Sends (MIN_FRAME − len_i) zero bytes; each bit updates the CRC.
- FCS: 32 bits; bit k (k = 0..31) is ~crc[31−k]. The CRC does not update during FCS. After the last FCS bit, txen_o = 0 and go to IFG.
- CRC: serial Galois LFSR, polynomial 0x04C11DB7.
  - Next crc = {crc[30:0], 0} ^ (poly if crc[31] ^ bit).
  - Equivalent to standard reflected CRC-32 on the wire.
- IFG:
  - txen_o = 0 and txd_o = 0 for IFG_BITS × CLK_DIV cycles.
  - Then done_o pulses for 1 cycle, the state returns to IDLE, and busy_o falls in the same cycle as done_o.
- abort_i: in PRE, SFD, DATA, PAD or FCS, txen_o = 0 on the next cycle, the holding register is flushed, and the state goes to IFG. Ignored in IDLE and IFG.
- Simultaneous events:
  - abort_i has priority over underrun (no underrun pulse).
  - A transfer on the same cycle as a byte-boundary load counts as available; the bypass path is required.
- Widths:
  - Byte counter is LEN_W+1 bits so it cannot overflow at the maximum length.
  - Pad count = max(0, MIN_FRAME − len_i).

Decomposition:
- Shared package mac_pkg holds:
  - tx_state_t enum: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
  - Constants: CRC32_POLY = 0x04C11DB7, CRC32_INIT = 0xFFFFFFFF, PRE_BYTE = 0x55, SFD_BYTE = 0xD5.
- One sub-module, mac_crc32_serial:
  - Inputs: clk, rst_n, init, en, bit.
  - Output: crc[31:0].
  - Reused later by the RX checker.

Test Plan:
- CLK_DIV=2, MIN_FRAME=0, len=9, stream "123456789" → after 64 preamble/SFD bits, 72 data bits, then FCS bytes 0x26 0x39 0xF4 0xCB on the wire; each bit held 2 cycles; done_o 192 cycles after txen_o falls.
- MIN_FRAME=60, len=14 → exactly 46 zero pad bytes after data; total txen_o high = (8+60+4)×8×CLK_DIV cycles; FCS matches the software CRC-32 of the 60 bytes.
- Stall data_valid_i low from byte 5 onward, len=20 → underrun_o pulses once at the byte-5 boundary; txen_o low the next cycle; no FCS; done_o after IFG.
- abort_i asserted mid-FCS → txen_o low the next cycle; done_o after the full IFG; no underrun_o pulse.
- start_i held during a frame → ignored; a second start_i in the cycle after done_o → new frame, txen_o high the following cycle.
- rst_ni pulsed low mid-DATA → all outputs 0 immediately; CRC register 0xFFFFFFFF; next start_i produces a correct frame.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: transmit state encoding and CRC/framing constants.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
    localparam logic [7:0]  PRE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE   = 8'hD5;

endpackage

// File: rtl/mac_crc32_serial.sv
// Bit-serial CRC-32 (Galois form, MSB-aligned register); shared by the TX framer and RX checker.
module mac_crc32_serial
    import mac_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= CRC32_INIT;
        end else if (i_init) begin
            r_crc <= CRC32_INIT;
        end else if (i_en) begin
            r_crc <= {r_crc[30:0], 1'b0} ^ ((r_crc[31] ^ i_bit) ? CRC32_POLY : '0);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/mac_tx_framer.sv
// Ethernet MAC transmit framer: preamble, SFD, data, padding, FCS and IFG, serialised LSB-first.
module mac_tx_framer
    import mac_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int LEN_W     = 11,
    parameter int MIN_FRAME = 60,
    parameter int PRE_BYTES = 7,
    parameter int IFG_BITS  = 96
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output logic             busy_o,
    input  logic [7:0]       data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             txen_o,
    output logic             txd_o,
    output logic             done_o,
    output logic             underrun_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = ($clog2(IFG_BITS) > 5) ? $clog2(IFG_BITS) : 5;
    localparam int LW1   = LEN_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BITS - 1);
    localparam logic [LEN_W:0]   PRE_LAST = LW1'(PRE_BYTES - 1);
    localparam logic [LEN_W:0]   MIN_LEN  = LW1'(MIN_FRAME);

    tx_state_t        r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [LEN_W:0]   r_byte_cnt, w_byte_nxt;
    logic [LEN_W:0]   r_acc_cnt;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_hold;
    logic             r_full;
    logic             r_done, w_done_nxt;

    logic             w_tick, w_ready, w_xfer, w_avail;
    logic             w_crc_init, w_crc_en, w_load, w_flush, w_underrun;
    logic [7:0]       w_byte_in;
    logic [LEN_W:0]   w_byte_inc, w_data_sent, w_len_ext;
    logic [31:0]      w_crc;
    logic [4:0]       w_fcs_idx;
    logic             w_txd;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_len_ext   = {1'b0, r_len};
    assign w_byte_inc  = r_byte_cnt + 1'b1;
    assign w_data_sent = (r_state == DATA) ? w_byte_inc : '0;
    assign w_ready     = !r_full && (r_acc_cnt < w_len_ext) &&
                         (r_state == PRE || r_state == SFD || r_state == DATA);
    assign w_xfer      = data_valid_i && w_ready;
    // A byte arriving in the boundary cycle itself is forwarded straight to the shifter.
    assign w_avail     = r_full || w_xfer;
    assign w_byte_in   = r_full ? r_hold : data_i;
    assign w_fcs_idx   = 5'd31 - r_cnt[4:0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_byte_nxt  = r_byte_cnt;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        w_crc_init  = 1'b0;
        w_crc_en    = 1'b0;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            IDLE: if (start_i) begin
                w_state_nxt = PRE;
                w_cnt_nxt   = '0;
                w_byte_nxt  = '0;
                w_shift_nxt = PRE_BYTE;
                w_crc_init  = 1'b1;
            end
            IFG: if (w_tick) begin
                if (r_cnt == IFG_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: if (abort_i) begin
                w_state_nxt = IFG;
                w_cnt_nxt   = '0;
                w_flush     = 1'b1;
            end else if (w_tick) begin
                if (r_state == FCS) begin
                    if (r_cnt[4:0] == 5'd31) begin
                        w_state_nxt = IFG;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_crc_en = (r_state == DATA) || (r_state == PAD);
                    if (r_cnt[2:0] != 3'd7) begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end else begin
                        w_cnt_nxt = '0;
                        if (r_state == PRE) begin
                            if (r_byte_cnt == PRE_LAST) begin
                                w_state_nxt = SFD;
                                w_byte_nxt  = '0;
                                w_shift_nxt = SFD_BYTE;
                            end else begin
                                w_byte_nxt  = w_byte_inc;
                                w_shift_nxt = PRE_BYTE;
                            end
                        end else if (r_state == PAD) begin
                            w_byte_nxt  = w_byte_inc;
                            w_shift_nxt = '0;
                            if (w_byte_inc == MIN_LEN) w_state_nxt = FCS;
                        end else begin
                            w_byte_nxt = w_data_sent;
                            if (w_data_sent == w_len_ext) begin
                                w_shift_nxt = '0;
                                w_state_nxt = (w_len_ext < MIN_LEN) ? PAD : FCS;
                            end else if (w_avail) begin
                                w_state_nxt = DATA;
                                w_shift_nxt = w_byte_in;
                                w_load      = 1'b1;
                            end else begin
                                w_state_nxt = IFG;
                                w_underrun  = 1'b1;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_byte_cnt <= w_byte_nxt;
            r_shift    <= w_shift_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div     <= '0;
            r_len     <= '0;
            r_acc_cnt <= '0;
            r_hold    <= '0;
            r_full    <= 1'b0;
        end else begin
            if (r_state == IDLE || w_flush || w_tick) r_div <= '0;
            else                                      r_div <= r_div + 1'b1;

            if (r_state == IDLE && start_i) begin
                r_len     <= len_i;
                r_acc_cnt <= '0;
            end else if (w_xfer) begin
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end

            if (w_flush || w_load) begin
                r_full <= 1'b0;
            end else if (w_xfer) begin
                r_full <= 1'b1;
                r_hold <= data_i;
            end
        end
    end

    mac_crc32_serial u_crc (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_init  (w_crc_init),
        .i_en    (w_crc_en),
        .i_bit   (r_shift[0]),
        .o_crc   (w_crc)
    );

    always_comb begin
        case (r_state)
            PRE, SFD, DATA, PAD: w_txd = r_shift[0];
            FCS:                 w_txd = ~w_crc[w_fcs_idx];
            default:             w_txd = 1'b0;
        endcase
    end

    assign busy_o       = (r_state != IDLE);
    assign txen_o       = (r_state != IDLE) && (r_state != IFG);
    assign txd_o        = w_txd;
    assign data_ready_o = w_ready;
    assign done_o       = r_done;
    assign underrun_o   = w_underrun;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: expected line samples are queued per frame and checked by a monitor.
`timescale 1ns/1ps
module tb_mac_tx_framer;

    localparam int CLK_DIV   = 2;
    localparam int LEN_W     = 11;
    localparam int MIN_FRAME = 60;
    localparam int PRE_BYTES = 7;
    localparam int IFG_BITS  = 96;
    localparam int IFG_CYC   = IFG_BITS * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic             abort_i = 1'b0;
    logic [7:0]       data_i = '0;
    logic             data_valid_i = 1'b0;
    logic             busy_o, data_ready_o, txen_o, txd_o, done_o, underrun_o;

    mac_tx_framer #(
        .CLK_DIV   (CLK_DIV),
        .LEN_W     (LEN_W),
        .MIN_FRAME (MIN_FRAME),
        .PRE_BYTES (PRE_BYTES),
        .IFG_BITS  (IFG_BITS)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .len_i        (len_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .txen_o       (txen_o),
        .txd_o        (txd_o),
        .done_o       (done_o),
        .underrun_o   (underrun_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int ur;
    } frame_t;

    logic       exp_bits[$];
    frame_t     exp_frames[$];
    logic [7:0] feed_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reflected CRC-32 as computed in software; FCS is its complement sent low byte first.
    function automatic logic [31:0] crc32_ref(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic expect_frame(input logic [7:0] data[$], input int nfeed, input int abort_n);
        logic [7:0]  wb[$];
        logic [7:0]  body[$];
        logic [31:0] fcs;
        int          ns;
        int          ur;
        ns = 0;
        ur = 0;
        for (int i = 0; i < PRE_BYTES; i++) wb.push_back(8'h55);
        wb.push_back(8'hD5);
        if (nfeed < data.size()) begin
            for (int i = 0; i < nfeed; i++) wb.push_back(data[i]);
            ur = (abort_n == 0) ? 1 : 0;
        end else begin
            body = data;
            while (body.size() < MIN_FRAME) body.push_back(8'h00);
            fcs = crc32_ref(body);
            foreach (body[i]) wb.push_back(body[i]);
            for (int k = 0; k < 4; k++) wb.push_back(fcs[8*k +: 8]);
        end
        foreach (wb[i])
            for (int b = 0; b < 8; b++)
                for (int r = 0; r < CLK_DIV; r++)
                    if (abort_n == 0 || ns < abort_n) begin
                        exp_bits.push_back(wb[i][b]);
                        ns++;
                    end
        exp_frames.push_back('{hi: ns, ur: ur});
    endtask

    task automatic begin_frame(input logic [7:0] data[$], input int nfeed, input int abort_n);
        expect_frame(data, nfeed, abort_n);
        feed_q.delete();
        for (int i = 0; i < nfeed; i++) feed_q.push_back(data[i]);
        @(posedge clk); #1;
        start_i = 1'b1;
        len_i   = LEN_W'(data.size());
        @(negedge clk);
        check("txen_before_start", txen_o, 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        len_i   = LEN_W'($urandom);
        @(negedge clk);
        check("txen_after_start", txen_o, 1);
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done_o !== 1'b1 && t < 20000);
        check("done_seen", done_o, 1);
    endtask

    task automatic run_frame(input logic [7:0] data[$], input int nfeed, input int abort_n,
                             input int hold_start);
        begin_frame(data, nfeed, abort_n);
        if (hold_start != 0) begin
            @(posedge clk); #1;
            start_i = 1'b1;
            repeat (40) @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        if (abort_n > 0) begin
            repeat (abort_n - 1) @(posedge clk);
            #1;
            abort_i = 1'b1;
            @(posedge clk); #1;
            abort_i = 1'b0;
        end
        wait_done();
    endtask

    function automatic void rand_data(input int len, output logic [7:0] d[$]);
        d.delete();
        for (int i = 0; i < len; i++) d.push_back(8'($urandom));
    endfunction

    // Byte-stream source with random bubbles; handshake decided mid-cycle.
    initial begin : feeder
        bit xfer;
        forever begin
            @(negedge clk);
            xfer = (data_valid_i && data_ready_o);
            @(posedge clk); #1;
            if (xfer && feed_q.size() > 0) void'(feed_q.pop_front());
            if (feed_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                data_valid_i = 1'b1;
                data_i       = feed_q[0];
            end else begin
                data_valid_i = 1'b0;
                data_i       = 8'($urandom);
            end
        end
    end

    initial begin : monitor
        bit     prev_txen;
        bit     in_ifg;
        int     hi, lo, ur, cur_ur;
        frame_t f;
        logic   e;
        prev_txen = 0; in_ifg = 0; hi = 0; lo = 0; ur = 0; cur_ur = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                prev_txen = 0; in_ifg = 0; hi = 0; lo = 0; ur = 0;
                continue;
            end
            if (txen_o === 1'b1) begin
                hi++;
                if (exp_bits.size() == 0) begin
                    check("txen_extra", txen_o, 0);
                end else begin
                    e = exp_bits.pop_front();
                    check("txd", txd_o, e);
                end
            end else begin
                check("txd_idle", txd_o, 0);
            end
            if (underrun_o === 1'b1) begin
                ur++;
                check("underrun_last_txen", txen_o, 1);
            end
            if (prev_txen && txen_o !== 1'b1) begin
                in_ifg = 1;
                lo = 0;
                if (exp_frames.size() == 0) begin
                    check("frame_unexpected", hi, 0);
                    cur_ur = 0;
                end else begin
                    f = exp_frames.pop_front();
                    check("txen_cycles", hi, f.hi);
                    cur_ur = f.ur;
                end
                hi = 0;
            end
            if (done_o === 1'b1) begin
                check("done_in_ifg", in_ifg, 1);
                if (in_ifg) begin
                    check("ifg_cycles", lo, IFG_CYC);
                    check("underrun_pulses", ur, cur_ur);
                    check("busy_at_done", busy_o, 0);
                end
                in_ifg = 0;
                ur = 0;
            end else if (in_ifg) begin
                lo++;
            end
            prev_txen = (txen_o === 1'b1);
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] d[$];
        int         len, n;

        @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_txen", txen_o, 0);
        check("rst_txd", txd_o, 0);
        check("rst_done", done_o, 0);
        check("rst_underrun", underrun_o, 0);
        check("rst_ready", data_ready_o, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        repeat (3) @(posedge clk);

        d.delete();
        for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
        run_frame(d, 9, 0, 0);

        rand_data(14, d); run_frame(d, 14, 0, 0);
        rand_data(0, d);  run_frame(d, 0, 0, 0);
        rand_data(60, d); run_frame(d, 60, 0, 0);
        rand_data(61, d); run_frame(d, 61, 0, 0);

        rand_data(20, d); run_frame(d, 5, 0, 0);
        rand_data(10, d); run_frame(d, 0, 0, 0);

        len = 14;
        rand_data(len, d);
        n = ((8 + MIN_FRAME) * 8 + 10) * CLK_DIV + 1;
        run_frame(d, len, n, 0);

        len = 40;
        rand_data(len, d);
        n = $urandom_range(64 * CLK_DIV + 1, (8 + len) * 8 * CLK_DIV);
        run_frame(d, len, n, 0);

        rand_data(25, d); run_frame(d, 25, 0, 1);
        rand_data(33, d); run_frame(d, 33, 0, 0);

        rand_data(30, d);
        begin_frame(d, 30, 0);
        repeat (64 * CLK_DIV + 100) @(posedge clk);
        #1;
        rst_ni = 1'b0;
        exp_bits.delete();
        exp_frames.delete();
        feed_q.delete();
        @(negedge clk);
        check("midrst_busy", busy_o, 0);
        check("midrst_txen", txen_o, 0);
        check("midrst_txd", txd_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_underrun", underrun_o, 0);
        check("midrst_ready", data_ready_o, 0);
        check("midrst_crc", dut.u_crc.o_crc, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);

        rand_data(18, d); run_frame(d, 18, 0, 0);

        for (int k = 0; k < 4; k++) begin
            len = $urandom_range(0, 90);
            rand_data(len, d);
            run_frame(d, len, 0, 0);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
